mem2p_be: RTL and testbench

- Parametrised true dual-port synchronous RAM; next generation of the core's shared instruction/data memory.
- Generalised in data width, depth and read latency.
- Adds per-lane write enables, request/valid handshake and a reset-triggered clear sweep with busy flag.
- Defined behaviour for every same-address interaction between the two ports.

---
 rtl/mem2p_be_pkg.sv | 20 ++
 rtl/mem2p_rd_pipe.sv | 44 ++++
 rtl/mem2p_be.sv | 194 +++++++++++++++++++
 tb/tb_mem2p_be.sv | 283 ++++++++++++++++++++++++++++
 4 files changed

// File: rtl/mem2p_be_pkg.sv
// ---------------------------------------------------------------------------
// mem2p_be_pkg
// Shared definitions for the mem2p_be dual-port RAM: default geometry used by
// the module parameters, the port count, and the sweep/run state type.
// ---------------------------------------------------------------------------
package mem2p_be_pkg;

    localparam int DEF_DATA_W = 24;
    localparam int DEF_ADDR_W = 12;
    localparam int DEF_DEPTH  = 4096;
    localparam int DEF_LANE_W = 8;

    localparam int NPORTS = 2;

    typedef enum logic {
        S_CLEAR = 1'b0,
        S_RUN   = 1'b1
    } state_t;

endpackage

// File: rtl/mem2p_rd_pipe.sv
// ---------------------------------------------------------------------------
// mem2p_rd_pipe
// Optional second read-output register stage (read latency 2). One instance
// per port. A reset flushes the stage, so no in-flight read completes after
// reset. Data holds its last value while the stage carries no valid.
//
// Ports:
//   iw_clk    in   clock
//   iw_rst    in   synchronous active-high reset (flush)
//   iw_valid  in   first-stage read valid
//   iw_data   in   first-stage read data
//   iw_coll   in   first-stage collision flag
//   or_valid  out  registered read valid
//   or_data   out  registered read data
//   or_coll   out  registered collision flag
// ---------------------------------------------------------------------------
module mem2p_rd_pipe #(
    parameter int DATA_W = 24
) (
    input  logic              iw_clk,
    input  logic              iw_rst,
    input  logic              iw_valid,
    input  logic [DATA_W-1:0] iw_data,
    input  logic              iw_coll,
    output logic              or_valid,
    output logic [DATA_W-1:0] or_data,
    output logic              or_coll
);

    always_ff @(posedge iw_clk) begin
        if (iw_rst) begin
            or_valid <= 1'b0;
            or_data  <= '0;
            or_coll  <= 1'b0;
        end else begin
            or_valid <= iw_valid;
            or_coll  <= iw_coll;
            if (iw_valid) begin
                or_data <= iw_data;
            end
        end
    end

endmodule

// File: rtl/mem2p_be.sv
// ---------------------------------------------------------------------------
// mem2p_be
// True dual-port synchronous RAM with per-lane byte enables, request/valid
// handshake, optional zero-fill sweep after reset, and defined behaviour for
// every same-address interaction between the two ports.
//
// Ports (index 0/1 selects the port):
//   iw_clk         in   clock, all logic on posedge
//   iw_rst         in   synchronous active-high reset
//   iw_en[p]       in   access request
//   iw_we[p]       in   write when set, read otherwise
//   iw_be[p]       in   lane write enables (NLANES bits)
//   iw_addr[p]     in   word address
//   iw_wdata[p]    in   write data
//   or_rdata[p]    out  read data (holds while or_rvalid is low)
//   or_rvalid[p]   out  read data valid (raised for writes too)
//   or_busy        out  clear sweep in progress, requests ignored
//   or_collision   out  both ports wrote one address with overlapping lanes
// ---------------------------------------------------------------------------
module mem2p_be
    import mem2p_be_pkg::*;
#(
    parameter int DATA_W       = DEF_DATA_W,
    parameter int ADDR_W       = DEF_ADDR_W,
    parameter int DEPTH        = DEF_DEPTH,
    parameter int LANE_W       = DEF_LANE_W,
    parameter int RD_LAT       = 1,
    parameter int CLEAR_ON_RST = 1
) (
    input  logic                     iw_clk,
    input  logic                     iw_rst,
    input  logic                     iw_en    [0:NPORTS-1],
    input  logic                     iw_we    [0:NPORTS-1],
    input  logic [DATA_W/LANE_W-1:0] iw_be    [0:NPORTS-1],
    input  logic [ADDR_W-1:0]        iw_addr  [0:NPORTS-1],
    input  logic [DATA_W-1:0]        iw_wdata [0:NPORTS-1],
    output logic [DATA_W-1:0]        or_rdata [0:NPORTS-1],
    output logic                     or_rvalid[0:NPORTS-1],
    output logic                     or_busy,
    output logic                     or_collision
);

    localparam int NLANES = DATA_W / LANE_W;
    localparam int IDX_W  = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(DEPTH - 1);

    // Replace the lanes selected by be with new_w, keep the rest of old_w.
    function automatic logic [DATA_W-1:0] lane_merge(
        input logic [DATA_W-1:0] old_w,
        input logic [DATA_W-1:0] new_w,
        input logic [NLANES-1:0] be
    );
        logic [DATA_W-1:0] res;
        res = old_w;
        for (int l = 0; l < NLANES; l++) begin
            if (be[l]) begin
                res[l*LANE_W +: LANE_W] = new_w[l*LANE_W +: LANE_W];
            end
        end
        return res;
    endfunction

    logic [DATA_W-1:0] r_mem [DEPTH];
    state_t            r_state;
    logic [IDX_W-1:0]  r_clr_idx;
    logic              r_busy;
    logic [DATA_W-1:0] r_rdata  [NPORTS];
    logic              r_rvalid [NPORTS];
    logic              r_coll;

    logic              w_acc [NPORTS];
    logic              w_inr [NPORTS];
    logic              w_wr  [NPORTS];
    logic [IDX_W-1:0]  w_idx [NPORTS];
    logic [DATA_W-1:0] w_old [NPORTS];
    logic [DATA_W-1:0] w_rd  [NPORTS];
    logic              w_coll;

    // Request qualification, array lookup and cross-port forwarding.
    always_comb begin
        // NOTE: every signal gets a value on every path through this block so
        // no latch is inferred; here the loops assign all of them up front.
        for (int p = 0; p < NPORTS; p++) begin
            w_acc[p] = iw_en[p] & ~r_busy & ~iw_rst;
            w_inr[p] = 32'(iw_addr[p]) < DEPTH;
            w_idx[p] = iw_addr[p][IDX_W-1:0];
            w_wr[p]  = w_acc[p] & iw_we[p] & w_inr[p];
            w_old[p] = w_inr[p] ? r_mem[w_idx[p]] : '0;
        end
        // A port sees the other port's same-cycle write merged onto the old
        // word; its own write is never visible to itself (read-first).
        for (int p = 0; p < NPORTS; p++) begin
            w_rd[p] = w_old[p];
            if (w_inr[p] && w_wr[NPORTS-1-p] && (w_idx[NPORTS-1-p] == w_idx[p])) begin
                w_rd[p] = lane_merge(w_old[p], iw_wdata[NPORTS-1-p], iw_be[NPORTS-1-p]);
            end
        end
        w_coll = w_wr[0] & w_wr[1] & (w_idx[0] == w_idx[1]) & (|(iw_be[0] & iw_be[1]));
    end

    // NOTE: the array has no reset branch; zeroing is done by the clear sweep
    // so the storage can map onto RAM macros.
    always_ff @(posedge iw_clk) begin
        if ((r_state == S_CLEAR) && !iw_rst) begin
            r_mem[r_clr_idx] <= '0;
        end
        // Port 1 first, port 0 last: port 0 wins on overlapping lanes while
        // the non-overlapping lanes of both ports are kept.
        for (int p = NPORTS - 1; p >= 0; p--) begin
            for (int l = 0; l < NLANES; l++) begin
                if (w_wr[p] && iw_be[p][l]) begin
                    r_mem[w_idx[p]][l*LANE_W +: LANE_W] <= iw_wdata[p][l*LANE_W +: LANE_W];
                end
            end
        end
    end

    // Sweep/run FSM with registered busy flag.
    always_ff @(posedge iw_clk) begin
        if (iw_rst) begin
            r_clr_idx <= '0;
            if (CLEAR_ON_RST != 0) begin
                r_state <= S_CLEAR;
                r_busy  <= 1'b1;
            end else begin
                r_state <= S_RUN;
                r_busy  <= 1'b0;
            end
        end else begin
            case (r_state)
                S_CLEAR: begin
                    r_clr_idx <= r_clr_idx + 1'b1;
                    if (r_clr_idx == LAST_IDX) begin
                        r_state <= S_RUN;
                        r_busy  <= 1'b0;
                    end
                end
                default: begin
                    r_busy <= 1'b0;
                end
            endcase
        end
    end

    // First read stage: the memory output register.
    always_ff @(posedge iw_clk) begin
        // NOTE: sequential state uses non-blocking assignments so every
        // register samples pre-edge values regardless of statement order.
        if (iw_rst) begin
            for (int p = 0; p < NPORTS; p++) begin
                r_rvalid[p] <= 1'b0;
                r_rdata[p]  <= '0;
            end
            r_coll <= 1'b0;
        end else begin
            for (int p = 0; p < NPORTS; p++) begin
                r_rvalid[p] <= w_acc[p];
                if (w_acc[p]) begin
                    r_rdata[p] <= w_rd[p];
                end
            end
            r_coll <= w_coll;
        end
    end

    assign or_busy = r_busy;

    generate
        if (RD_LAT == 2) begin : g_lat2
            logic w_pcoll [NPORTS];
            for (genvar p = 0; p < NPORTS; p++) begin : g_port
                // Collision travels once, through port 0's stage.
                mem2p_rd_pipe #(.DATA_W(DATA_W)) u_pipe (
                    .iw_clk   (iw_clk),
                    .iw_rst   (iw_rst),
                    .iw_valid (r_rvalid[p]),
                    .iw_data  (r_rdata[p]),
                    .iw_coll  ((p == 0) ? r_coll : 1'b0),
                    .or_valid (or_rvalid[p]),
                    .or_data  (or_rdata[p]),
                    .or_coll  (w_pcoll[p])
                );
            end
            assign or_collision = w_pcoll[0] | w_pcoll[1];
        end else begin : g_lat1
            for (genvar p = 0; p < NPORTS; p++) begin : g_port
                assign or_rvalid[p] = r_rvalid[p];
                assign or_rdata[p]  = r_rdata[p];
            end
            assign or_collision = r_coll;
        end
    endgenerate

endmodule

// File: tb/tb_mem2p_be.sv
// ---------------------------------------------------------------------------
// tb_mem2p_be
// Two instances (read latency 1 and 2, DEPTH=16, 5-bit address so that
// out-of-range addresses are reachable) share one stimulus stream. The
// stimulus side keeps a word-array model and pushes each expected response,
// tagged with its arrival edge, into a per-instance/per-port queue; a negedge
// monitor pops and compares whenever a port raises or_rvalid.
// ---------------------------------------------------------------------------
module tb_mem2p_be;

    localparam int DW    = 24;
    localparam int AW    = 5;
    localparam int DEPTH = 16;
    localparam int LW    = 8;
    localparam int NL    = DW / LW;

    typedef struct {
        int          arrival;
        logic [DW-1:0] data;
        logic        coll;
    } exp_t;

    logic          clk = 1'b0;
    logic          rst = 1'b1;
    logic          rst_q = 1'b1;
    logic          en    [0:1];
    logic          we    [0:1];
    logic [NL-1:0] be    [0:1];
    logic [AW-1:0] addr  [0:1];
    logic [DW-1:0] wdata [0:1];

    logic [DW-1:0] rd_a [0:1];
    logic [DW-1:0] rd_b [0:1];
    logic          rv_a [0:1];
    logic          rv_b [0:1];
    logic          busy_a, busy_b, coll_a, coll_b;

    int n_tests = 0;
    int n_fail  = 0;
    int edge_n  = 0;
    int rst_edge = 0;

    logic [DW-1:0] model [DEPTH];
    exp_t          sb [4][$];
    logic [DW-1:0] hold [4];

    mem2p_be #(.DATA_W(DW), .ADDR_W(AW), .DEPTH(DEPTH), .LANE_W(LW),
               .RD_LAT(1), .CLEAR_ON_RST(1)) u_dut_l1 (
        .iw_clk(clk), .iw_rst(rst), .iw_en(en), .iw_we(we), .iw_be(be),
        .iw_addr(addr), .iw_wdata(wdata), .or_rdata(rd_a), .or_rvalid(rv_a),
        .or_busy(busy_a), .or_collision(coll_a)
    );

    mem2p_be #(.DATA_W(DW), .ADDR_W(AW), .DEPTH(DEPTH), .LANE_W(LW),
               .RD_LAT(2), .CLEAR_ON_RST(1)) u_dut_l2 (
        .iw_clk(clk), .iw_rst(rst), .iw_en(en), .iw_we(we), .iw_be(be),
        .iw_addr(addr), .iw_wdata(wdata), .or_rdata(rd_b), .or_rvalid(rv_b),
        .or_busy(busy_b), .or_collision(coll_b)
    );

    always #5 clk = ~clk;

    always @(posedge clk) begin
        edge_n <= edge_n + 1;
        rst_q  <= rst;
    end

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h, expected %0h (edge %0d)", name, act, exp, edge_n);
        end
    endtask

    // Lane-masked overwrite computed with plain masks.
    function automatic logic [DW-1:0] merge(input logic [DW-1:0] old_w,
                                            input logic [DW-1:0] new_w,
                                            input logic [NL-1:0] b);
        logic [DW-1:0] mask;
        mask = '0;
        for (int l = 0; l < NL; l++) begin
            if (b[l]) mask = mask | (24'hFF << (LW * l));
        end
        return (old_w & ~mask) | (new_w & mask);
    endfunction

    // Drive one cycle of requests and record the expected responses.
    task automatic issue(input logic e0, input logic w0, input logic [NL-1:0] b0,
                         input logic [AW-1:0] a0, input logic [DW-1:0] d0,
                         input logic e1, input logic w1, input logic [NL-1:0] b1,
                         input logic [AW-1:0] a1, input logic [DW-1:0] d1);
        int t;
        logic acc [2];
        logic inr [2];
        logic wr  [2];
        logic cl;
        logic [DW-1:0] rdv;
        exp_t e;
        @(posedge clk); #1;
        en[0] = e0; we[0] = w0; be[0] = b0; addr[0] = a0; wdata[0] = d0;
        en[1] = e1; we[1] = w1; be[1] = b1; addr[1] = a1; wdata[1] = d1;
        t = edge_n + 1;
        for (int p = 0; p < 2; p++) begin
            acc[p] = en[p] && !rst && (t > rst_edge + DEPTH);
            inr[p] = int'(addr[p]) < DEPTH;
            wr[p]  = acc[p] && we[p] && inr[p];
        end
        cl = wr[0] && wr[1] && (addr[0] == addr[1]) && ((be[0] & be[1]) != '0);
        for (int p = 0; p < 2; p++) begin
            if (acc[p]) begin
                rdv = '0;
                if (inr[p]) begin
                    rdv = model[addr[p][3:0]];
                    if (wr[1-p] && addr[1-p] == addr[p]) rdv = merge(rdv, wdata[1-p], be[1-p]);
                end
                for (int lat = 1; lat <= 2; lat++) begin
                    e.arrival = t + lat - 1;
                    e.data    = rdv;
                    e.coll    = cl;
                    sb[(lat-1)*2 + p].push_back(e);
                end
            end
        end
        if (wr[1]) model[addr[1][3:0]] = merge(model[addr[1][3:0]], wdata[1], be[1]);
        if (wr[0]) model[addr[0][3:0]] = merge(model[addr[0][3:0]], wdata[0], be[0]);
    endtask

    task automatic idle(input int n);
        repeat (n) begin
            @(posedge clk); #1;
            en[0] = 1'b0;
            en[1] = 1'b0;
        end
    endtask

    // One-cycle reset; responses due at or after the reset edge are flushed.
    task automatic do_reset();
        @(posedge clk); #1;
        rst = 1'b1;
        en[0] = 1'b0;
        en[1] = 1'b0;
        rst_edge = edge_n + 1;
        for (int i = 0; i < 4; i++) begin
            while (sb[i].size() > 0 && sb[i][$].arrival >= rst_edge) void'(sb[i].pop_back());
        end
        for (int a = 0; a < DEPTH; a++) model[a] = '0;
        @(posedge clk); #1;
        rst = 1'b0;
    endtask

    // Busy must fall exactly DEPTH edges after the last reset edge.
    task automatic wait_busy_done(input string name);
        int na = -1;
        int nb = -1;
        idle(1);
        for (int i = 0; i < 100 && (na < 0 || nb < 0); i++) begin
            @(negedge clk);
            if (!busy_a && na < 0) na = edge_n - rst_edge;
            if (!busy_b && nb < 0) nb = edge_n - rst_edge;
        end
        check({name, "_l1"}, 32'(na), 32'(DEPTH));
        check({name, "_l2"}, 32'(nb), 32'(DEPTH));
    endtask

    // Monitor: index i = dut*2 + port.
    logic          mv, mc;
    logic [DW-1:0] md;
    exp_t          me;
    string         mn;

    always @(negedge clk) begin
        for (int i = 0; i < 4; i++) begin
            mv = (i < 2) ? rv_a[i % 2] : rv_b[i % 2];
            md = (i < 2) ? rd_a[i % 2] : rd_b[i % 2];
            mc = (i < 2) ? coll_a : coll_b;
            mn = $sformatf("L%0d_P%0d", i / 2 + 1, i % 2);
            if (rst_q) begin
                check({"rst_valid_", mn}, 32'(mv), 32'd0);
                check({"rst_data_", mn}, 32'(md), 32'd0);
                check({"rst_coll_", mn}, 32'(mc), 32'd0);
                hold[i] = '0;
            end else if (mv) begin
                if (sb[i].size() == 0) begin
                    check({"unexpected_valid_", mn}, 32'(mv), 32'd0);
                end else begin
                    me = sb[i].pop_front();
                    check({"latency_", mn}, 32'(edge_n), 32'(me.arrival));
                    check({"rdata_", mn}, 32'(md), 32'(me.data));
                    check({"collision_", mn}, 32'(mc), 32'(me.coll));
                end
                hold[i] = md;
            end else begin
                check({"hold_", mn}, 32'(md), 32'(hold[i]));
                check({"idle_coll_", mn}, 32'(mc), 32'd0);
                if (sb[i].size() > 0 && sb[i][0].arrival <= edge_n) begin
                    check({"missing_valid_", mn}, 32'(mv), 32'd1);
                    void'(sb[i].pop_front());
                end
            end
        end
    end

    initial begin
        #500000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1, "watchdog");
    end

    initial begin
        logic [AW-1:0] ra;
        for (int p = 0; p < 2; p++) begin
            en[p] = 1'b0; we[p] = 1'b0; be[p] = '0; addr[p] = '0; wdata[p] = '0;
        end

        // Reset sweep; requests during busy are dropped (incl. a write).
        do_reset();
        issue(1, 0, 3'b000, 5'd2, 24'h0, 1, 1, 3'b111, 5'd2, 24'hFFFFFF);
        issue(1, 1, 3'b111, 5'd4, 24'h123123, 1, 0, 3'b000, 5'd4, 24'h0);
        issue(1, 0, 3'b000, 5'd16, 24'h0, 0, 0, 3'b000, 5'd0, 24'h0);
        wait_busy_done("busy_len_reset");
        for (int a = 0; a < DEPTH; a++) begin
            issue(1, 0, 3'b000, AW'(a), 24'h0, 1, 0, 3'b000, AW'(DEPTH - 1 - a), 24'h0);
        end

        // Write then cross-port read.
        issue(1, 1, 3'b111, 5'd5, 24'hABCDEF, 0, 0, 3'b000, 5'd0, 24'h0);
        issue(0, 0, 3'b000, 5'd0, 24'h0, 1, 0, 3'b000, 5'd5, 24'h0);
        // Lane write.
        issue(1, 1, 3'b111, 5'd7, 24'h112233, 0, 0, 3'b000, 5'd0, 24'h0);
        issue(1, 1, 3'b010, 5'd7, 24'hAABBCC, 0, 0, 3'b000, 5'd0, 24'h0);
        issue(0, 0, 3'b000, 5'd0, 24'h0, 1, 0, 3'b000, 5'd7, 24'h0);
        // Same-cycle cross port write/read.
        issue(1, 1, 3'b111, 5'd9, 24'h000000, 0, 0, 3'b000, 5'd0, 24'h0);
        issue(1, 1, 3'b111, 5'd9, 24'h123456, 1, 0, 3'b000, 5'd9, 24'h0);
        // Dual writes, overlapping and disjoint lanes.
        issue(1, 1, 3'b110, 5'd3, 24'hAAAAAA, 1, 1, 3'b011, 5'd3, 24'h555555);
        issue(1, 0, 3'b000, 5'd3, 24'h0, 0, 0, 3'b000, 5'd0, 24'h0);
        issue(1, 1, 3'b100, 5'd3, 24'hAAAAAA, 1, 1, 3'b011, 5'd3, 24'h555555);
        issue(0, 0, 3'b000, 5'd0, 24'h0, 1, 0, 3'b000, 5'd3, 24'h0);
        // Zero-lane write and out-of-range accesses.
        issue(1, 1, 3'b000, 5'd5, 24'h777777, 1, 0, 3'b000, 5'd5, 24'h0);
        issue(1, 1, 3'b111, 5'd16, 24'hDEADBE, 1, 0, 3'b000, 5'd16, 24'h0);
        issue(1, 0, 3'b000, 5'd31, 24'h0, 1, 0, 3'b000, 5'd0, 24'h0);

        // Randomized back-to-back traffic, biased towards shared addresses.
        repeat (400) begin
            ra = AW'($urandom_range(0, 19));
            issue(1'($urandom_range(0, 3) != 0), 1'($urandom_range(0, 1)),
                  NL'($urandom_range(0, 7)), ra, DW'($urandom),
                  1'($urandom_range(0, 3) != 0), 1'($urandom_range(0, 1)),
                  NL'($urandom_range(0, 7)),
                  ($urandom_range(0, 2) == 0) ? ra : AW'($urandom_range(0, 19)),
                  DW'($urandom));
        end
        idle(3);

        // Reset while the sweep sits at index 10 restarts it.
        do_reset();
        idle(9);
        check("busy_mid_l1", 32'(busy_a), 32'd1);
        check("busy_mid_l2", 32'(busy_b), 32'd1);
        do_reset();
        wait_busy_done("busy_len_midsweep");

        // Reset with reads in flight: the latency-2 responses never appear.
        issue(1, 1, 3'b111, 5'd6, 24'h5A5A5A, 0, 0, 3'b000, 5'd0, 24'h0);
        issue(1, 0, 3'b000, 5'd6, 24'h0, 1, 0, 3'b000, 5'd16, 24'h0);
        do_reset();
        wait_busy_done("busy_len_inflight");
        issue(1, 0, 3'b000, 5'd16, 24'h0, 1, 0, 3'b000, 5'd6, 24'h0);
        issue(1, 0, 3'b000, 5'd20, 24'h0, 1, 1, 3'b101, 5'd6, 24'h0F0F0F);
        issue(0, 0, 3'b000, 5'd0, 24'h0, 1, 0, 3'b000, 5'd6, 24'h0);
        idle(6);

        for (int i = 0; i < 4; i++) begin
            check($sformatf("drain_%0d", i), 32'(sb[i].size()), 32'd0);
        end
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
